// File: rtl/als_pkg.sv
// Shared definitions for the PmodALS light-sensor path: display modes,
// capture FSM states and ADC frame field positions.
package als_pkg;

  localparam logic [1:0] MODE_THRESH = 2'b00;
  localparam logic [1:0] MODE_RAW    = 2'b01;
  localparam logic [1:0] MODE_BAR    = 2'b10;
  localparam logic [1:0] MODE_PEAK   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } cap_state_e;

  // ADC frame: 3 leading zeros, 8 data bits, 5 trailing bits
  localparam int DATA_MSB   = 12;
  localparam int DATA_LSB   = 5;
  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/als_spi_rx.sv
// SPI capture of one PmodALS frame per cycle of the capture FSM; cs and sck
// are registered so reset forces both high without waiting for a clock.
module als_spi_rx
  import als_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdo,
  output logic       cs,
  output logic       sck,
  output logic [7:0] raw,
  output logic       raw_valid,
  output cap_state_e state
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  cap_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SETUP;
        cs_d    = 1'b0;
        cnt_d   = '0;
      end
      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            // sample on the same clk edge that raises sck
            sck_d   = 1'b1;
            shift_d = {shift_q[FRAME_BITS-2:0], sdo};
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
            cs_d    = 1'b1;
          end else begin
            sck_d = 1'b0;
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // raw_valid is a single-cycle pulse with no back-pressure: the consumer
  // must take raw on the cycle raw_valid is high.
  assign raw       = shift_q[DATA_MSB:DATA_LSB];
  assign raw_valid = (state_q == ST_DONE);
  assign cs        = cs_q;
  assign sck       = sck_q;
  assign state     = state_q;

endmodule

// File: rtl/als_led_display.sv
// Ambient-light display: averages PmodALS samples, tracks a peak and maps
// the result onto an LED bank in one of four switch-selected modes.
module als_led_display
  import als_pkg::*;
#(
  parameter int LED_W      = 16,
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 1000,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdo,
  input  logic [1:0]       mode,
  input  logic [7:0]       thresh,
  output logic             cs,
  output logic             sck,
  output logic [LED_W-1:0] led,
  output logic [7:0]       sample,
  output logic             sample_valid
);

  localparam int SUM_W    = 8 + AVG_LOG2;
  localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AVG_LAST = (1 << AVG_LOG2) - 1;

  logic [7:0] raw;
  logic       raw_valid;
  cap_state_e cap_state;

  als_spi_rx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_spi_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdo      (sdo),
    .cs       (cs),
    .sck      (sck),
    .raw      (raw),
    .raw_valid(raw_valid),
    .state    (cap_state)
  );

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [7:0]       sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;
  logic [7:0]       peak_q, peak_d;
  logic [1:0]       mode_q;
  logic [LED_W-1:0] led_q, led_d;

  logic [SUM_W-1:0] total;
  logic [7:0]       avg_val;
  logic             raw_fire;
  logic             avg_fire;
  logic             enter_peak;
  logic [7:0]       peak_view;

  function automatic logic [LED_W-1:0] bar_mask(input logic [7:0] v);
    logic [15:0]      prod;
    logic [LED_W-1:0] m;
    prod = 16'(v) * 16'(LED_W + 1);
    for (int i = 0; i < LED_W; i++) begin
      m[i] = (i < int'(prod[15:8]));
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q          <= '0;
      acnt_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      peak_q         <= '0;
      mode_q         <= MODE_THRESH;
      led_q          <= '0;
    end else begin
      sum_q          <= sum_d;
      acnt_q         <= acnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      peak_q         <= peak_d;
      mode_q         <= mode;
      led_q          <= led_d;
    end
  end

  always_comb begin
    raw_fire       = raw_valid && (cap_state == ST_DONE);
    total          = sum_q + SUM_W'(raw);
    avg_val        = total[SUM_W-1:AVG_LOG2];
    avg_fire       = raw_fire && (acnt_q == CNT_W'(AVG_LAST));
    sum_d          = sum_q;
    acnt_d         = acnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (avg_fire) begin
      sum_d          = '0;
      acnt_d         = '0;
      sample_d       = avg_val;
      sample_valid_d = 1'b1;
    end else if (raw_fire) begin
      sum_d  = total;
      acnt_d = acnt_q + 1'b1;
    end
  end

  // Entering peak mode restarts the peak; a coincident sample seeds it.
  always_comb begin
    enter_peak = (mode == MODE_PEAK) && (mode_q != MODE_PEAK);
    peak_d     = peak_q;
    if (enter_peak) begin
      peak_d = avg_fire ? avg_val : 8'd0;
    end else if (avg_fire && (avg_val > peak_q)) begin
      peak_d = avg_val;
    end
    peak_view = enter_peak ? 8'd0 : peak_q;
  end

  always_comb begin
    led_d = '0;
    case (mode)
      MODE_THRESH: led_d = (sample_q <= thresh) ? '1 : '0;
      MODE_RAW:    led_d = LED_W'(sample_q);
      MODE_BAR:    led_d = bar_mask(sample_q);
      MODE_PEAK:   led_d = bar_mask(peak_view);
      default:     led_d = '0;
    endcase
  end

  assign led          = led_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_als_led_display.sv
// Directed bench: two display instances (pass-through and 4-sample average)
// fed by PmodALS sensor models, checked with immediate assertions.
module tb_als_led_display;

  localparam int LED_W   = 16;
  localparam int CLK_DIV = 2;
  localparam int GAP     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic [7:0]       thresh;
  logic             sdo0 = 1'b0, sdo2 = 1'b0;
  logic             cs0, cs2, sck0, sck2, valid0, valid2;
  logic [LED_W-1:0] led0, led2;
  logic [7:0]       sample0, sample2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  als_led_display #(.LED_W(LED_W), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sdo(sdo0), .mode(mode), .thresh(thresh),
    .cs(cs0), .sck(sck0), .led(led0), .sample(sample0), .sample_valid(valid0)
  );

  als_led_display #(.LED_W(LED_W), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sdo(sdo2), .mode(mode), .thresh(thresh),
    .cs(cs2), .sck(sck2), .led(led2), .sample(sample2), .sample_valid(valid2)
  );

  // sensor models: frame {000, data, 00000}, next bit driven on each sck fall
  logic [7:0]  adc0_q[$];
  logic [7:0]  adc2_q[$];
  logic [7:0]  cur0 = 8'h00, cur2 = 8'h00;
  logic [15:0] fr0 = 16'h0, fr2 = 16'h0;
  int          idx0 = -1, idx2 = -1;
  logic        pcs0 = 1'b1, psck0 = 1'b1, pcs2 = 1'b1, psck2 = 1'b1;
  int          low_cnt0 = 0, rise_cnt0 = 0, last_low0 = 0, last_rises0 = 0;
  int          valid2_cnt = 0;
  int          sck_viol = 0;

  always @(negedge clk) begin
    if (pcs0 && !cs0) begin
      if (adc0_q.size() > 0) cur0 = adc0_q.pop_front();
      fr0  = {3'b000, cur0, 5'b00000};
      idx0 = 15;
    end else if (!cs0 && psck0 && !sck0 && idx0 >= 0) begin
      sdo0 = fr0[idx0];
      idx0--;
    end
    if (!cs0) low_cnt0++;
    if (!cs0 && !psck0 && sck0) rise_cnt0++;
    if (!pcs0 && cs0) begin
      last_low0   = low_cnt0;
      last_rises0 = rise_cnt0;
      low_cnt0    = 0;
      rise_cnt0   = 0;
    end
    if ((cs0 && !sck0) || (cs2 && !sck2)) sck_viol++;
    pcs0  = cs0;
    psck0 = sck0;
  end

  always @(negedge clk) begin
    if (pcs2 && !cs2) begin
      if (adc2_q.size() > 0) cur2 = adc2_q.pop_front();
      fr2  = {3'b000, cur2, 5'b00000};
      idx2 = 15;
    end else if (!cs2 && psck2 && !sck2 && idx2 >= 0) begin
      sdo2 = fr2[idx2];
      idx2--;
    end
    if (valid2) valid2_cnt++;
    pcs2  = cs2;
    psck2 = sck2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 0: cs0 rises, 1: cs0 falls, 2: sck0 low while cs0 low
  task automatic wait_for(input string tag, input int kind);
    logic p;
    logic seen;
    p    = cs0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      case (kind)
        0:       seen = !p && cs0;
        1:       seen = p && !cs0;
        default: seen = !cs0 && !sck0;
      endcase
      p = cs0;
    end
    check({tag, "_reached"}, seen, 1'b1);
  endtask

  task automatic frame_sample(input string tag, input logic [7:0] exp_sample);
    wait_for(tag, 0);
    check({tag, "_valid_pre"}, valid0, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, valid0, 1'b1);
    check({tag, "_sample"}, sample0, exp_sample);
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = 2'b00;
    thresh = 8'h40;
    adc0_q = '{8'hA5, 8'h40, 8'h41, 8'h00, 8'h80, 8'hFF, 8'hC8, 8'h32, 8'h11, 8'h77, 8'h3C};
    adc2_q = '{8'd10, 8'd20, 8'd30, 8'd41};
    repeat (3) @(negedge clk);
    check("rst_cs", cs0, 1'b1);
    check("rst_sck", sck0, 1'b1);
    check("rst_led", led0, 16'h0000);
    check("rst_sample", sample0, 8'h00);
    check("rst_valid", valid0, 1'b0);
    check("rst_cs_avg", cs2, 1'b1);
    rst_n = 1'b1;

    // frame 1: 0xA5, threshold mode, dark before the sample arrives
    frame_sample("f1", 8'hA5);
    check("f1_cs_low_cycles", last_low0, 66);
    check("f1_sck_rises", last_rises0, 16);
    check("f1_led_before", led0, 16'hFFFF);
    @(negedge clk);
    check("f1_pulse_end", valid0, 1'b0);
    check("f1_led_bright", led0, 16'h0000);

    frame_sample("f2", 8'h40);
    check("f2_led_before", led0, 16'h0000);
    @(negedge clk);
    check("f2_led_at_thresh", led0, 16'hFFFF);

    frame_sample("f3", 8'h41);
    check("f3_led_before", led0, 16'hFFFF);
    @(negedge clk);
    check("f3_led_above", led0, 16'h0000);
    check("avg_no_valid_3", valid2_cnt, 0);

    mode = 2'b01;
    @(negedge clk);
    check("raw_mode_led", led0, 16'h0041);
    mode = 2'b10;
    @(negedge clk);
    check("bar_mode_0x41", led0, 16'h000F);

    frame_sample("f4", 8'h00);
    @(negedge clk);
    check("bar_0", led0, 16'h0000);
    check("avg_one_valid", valid2_cnt, 1);
    check("avg_value", sample2, 8'd25);

    frame_sample("f5", 8'h80);
    @(negedge clk);
    check("bar_128", led0, 16'h00FF);

    frame_sample("f6", 8'hFF);
    @(negedge clk);
    check("bar_255", led0, 16'hFFFF);

    mode = 2'b11;
    @(negedge clk);
    check("peak_enter_clear", led0, 16'h0000);
    @(negedge clk);
    check("peak_enter_hold", led0, 16'h0000);

    frame_sample("f7", 8'hC8);
    @(negedge clk);
    check("peak_200", led0, 16'h1FFF);

    frame_sample("f8", 8'h32);
    @(negedge clk);
    check("peak_held", led0, 16'h1FFF);
    mode = 2'b01;
    @(negedge clk);
    check("peak_to_raw", led0, 16'h0032);
    mode = 2'b11;
    @(negedge clk);
    check("peak_reenter", led0, 16'h0000);
    repeat (3) @(negedge clk);
    check("peak_still_clear", led0, 16'h0000);
    mode = 2'b01;

    frame_sample("f9", 8'h11);
    @(negedge clk);
    check("f9_led", led0, 16'h0011);

    // reset in the middle of frame 10's shift phase, with sck low
    wait_for("f10_cs_fall", 1);
    wait_for("f10_sck_low", 2);
    check("mid_cs_low", cs0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", cs0, 1'b1);
    check("mid_rst_sck", sck0, 1'b1);
    check("mid_rst_led", led0, 16'h0000);
    check("mid_rst_sample", sample0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    frame_sample("post_rst", 8'h3C);
    check("post_rst_cs_low", last_low0, 66);
    check("post_rst_rises", last_rises0, 16);
    @(negedge clk);
    check("post_rst_pulse_end", valid0, 1'b0);
    check("post_rst_led", led0, 16'h003C);

    check("sck_high_when_cs_high", sck_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/als_led_display.md
# als_led_display

Parametrised ambient-light display block for the PmodALS board: owns the SPI capture of the sensor's 8-bit ADC sample, averages a configurable number of samples, and drives an LED bank in one of four switch-selected modes. It sits directly between the PmodALS pins (cs, sck, sdo) and the board LEDs/switches. This is the top of the light-sensor path, with the ADC capture in a dedicated sub-module.

## Interface
- LED_W, 16: number of LEDs driven (8..32).
- CLK_DIV, 50: clk cycles per sck half-period (≥2).
- GAP_CYCLES, 1000: clk cycles cs is held high between frames (≥1).
- AVG_LOG2, 2: log2 of samples per average (0..4).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sdo  in  1  PmodALS serial data.
- mode  in  2  display mode: 00 threshold, 01 raw, 10 bar, 11 peak.
- thresh  in  8  threshold for mode 00.
- cs  out  1  PmodALS chip select, active low.
- sck  out  1  PmodALS serial clock, idles high.
- led  out  LED_W  LED bank, 1 = lit.
- sample  out  8  latest averaged light value.
- sample_valid  out  1  one-cycle pulse when sample updates.

## Operation
- Reset values: cs=1, sck=1, led=0, sample=0, sample_valid=0, accumulator/count/peak=0.
- Capture FSM (sub-module) states: IDLE → SETUP → SHIFT → DONE → GAP → SETUP...
  - IDLE: one cycle after reset release, go to SETUP.
  - SETUP: cs=0, sck=1 for CLK_DIV cycles.
  - SHIFT: 16 sck periods; sck low CLK_DIV cycles then high CLK_DIV cycles; sdo shifted in MSB-first on the clk cycle where sck rises.
  - DONE: cs=1; raw sample = shift bits [12:5] (3 leading zeros, 8 data, 5 trailing); raw_valid pulse 1 cycle.
  - GAP: cs=1 for GAP_CYCLES, then SETUP.
- Averager: accumulates raw samples in an (8+AVG_LOG2)-bit sum; on the 2^AVG_LOG2-th sample, sample <= (sum + new) >> AVG_LOG2 (truncating), sample_valid pulses, sum and count clear. AVG_LOG2=0: every raw sample passes through.
- Peak register: on each sample_valid, peak <= max(peak, new sample). Cleared to 0 on the cycle mode changes to 11 from another mode; if sample_valid coincides, peak loads the new sample.
- LED mapping (registered, recomputed every cycle from current mode, sample, peak, thresh):
  - 00: all ones if sample <= thresh (dark), else all zero.
  - 01: led[7:0] = sample, upper bits 0.
  - 10: n = (sample × (LED_W+1)) >> 8; led[n-1:0] lit, rest 0; n=0 → all off.
  - 11: same bar mapping applied to peak.
- Mode/thresh changes take effect without waiting for a new sample.

## Timing
- sck period = 2·CLK_DIV clk; frame length = CLK_DIV + 32·CLK_DIV + 1 + GAP_CYCLES clk.
- raw_valid → sample/sample_valid: 1 clk. sample/mode/thresh change → led: 1 clk.
- cs never changes while sck low; sck held 1 whenever cs=1.
- Reset mid-frame: cs returns to 1 and sck to 1 immediately (asynchronously); partial shift data and partial averages discarded; first frame restarts via IDLE.
- Counters saturate nowhere: sum width guarantees no overflow at 2^AVG_LOG2 × 255.

## Structure
- Shared package als_pkg: mode encodings (MODE_THRESH, MODE_RAW, MODE_BAR, MODE_PEAK), capture FSM state enum, data-bit field positions (DATA_MSB=12, DATA_LSB=5, FRAME_BITS=16).
- Sub-module als_spi_rx: capture FSM, sck divider, shift register; outputs raw[7:0], raw_valid, cs, sck. Averager, peak and LED mapping in the top.

## Test plan
- Reset then sensor model returning 0xA5, AVG_LOG2=0, CLK_DIV=2: cs low for exactly 2+64 clk, 16 sck rising edges, sample=0xA5 with one-cycle sample_valid 1 clk after cs rises.
- AVG_LOG2=2, samples 10,20,30,41 → single sample_valid, sample=25; no valid pulse after first three.
- Mode 10, LED_W=16: sample 0 → led=0x0000; 128 → 0x00FF; 255 → 0xFFFF.
- Mode 00, thresh=0x40: sample 0x40 → led=0xFFFF; sample 0x41 → led=0x0000 one clk after update.
- Mode 11: samples 200, 50 → bar of 200 (n=13, led=0x1FFF) held; switch to 01 and back to 11 → peak cleared, led=0 until next sample.
- rst_n asserted mid-SHIFT: cs=1, sck=1, led=0 same cycle; after release, next frame starts from SETUP and yields correct sample.
